// File: rtl/dir_mapp_cache.sv
// dir_mapp_cache
//   Direct-mapped, write-through, no-write-allocate cache with one-word lines.
//   The cache handles one CPU request at a time. It refills a line on a read
//   miss, writes every store through to memory, and keeps saturating hit and
//   miss counters.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req/rw/addr/wdata      CPU request (accepted when cpu_ready=1)
//   cpu_ready                  idle and no flush pending
//   cpu_done, cpu_rdata        one-cycle completion pulse, read data
//   flush                      invalidate all lines (deferred while busy)
//   mem_req/we/addr/wdata      backing-memory request, held until mem_ack
//   mem_ack, mem_rdata         memory completion, read data valid with ack
//   hit_cnt, miss_cnt          saturating statistics
module dir_mapp_cache #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    output logic               cpu_ready,
    input  logic               cpu_rw,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_done,
    output logic [DATA_W-1:0]  cpu_rdata,
    input  logic               flush,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [COUNT_W-1:0] hit_cnt,
    output logic [COUNT_W-1:0] miss_cnt
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, CMP, MEM_RD, MEM_WR} state_t;

    state_t               state_q, state_d;
    logic                 rw_q, rw_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 done_q, done_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [COUNT_W-1:0]   hit_q, hit_d;
    logic [COUNT_W-1:0]   miss_q, miss_d;

    // Tag and data storage; deliberately not reset, valid bits gate their use.
    logic [TAG_W-1:0]     tag_arr  [LINES];
    logic [DATA_W-1:0]    data_arr [LINES];
    logic                 data_we, tag_we;
    logic [DATA_W-1:0]    data_wval;

    logic [INDEX_W-1:0]   idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic                 unused_addr_lsb;

    // Byte offset within the word is irrelevant to a word-wide cache.
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign idx = addr_q[INDEX_W+1:2];
    assign tag = addr_q[ADDR_W-1:INDEX_W+2];
    assign hit = valid_q[idx] && (tag_arr[idx] == tag);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        done_d       = 1'b0;
        rdata_d      = rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        data_wval    = '0;

        unique case (state_q)
            IDLE: begin
                // A flush (live or deferred) wins over a simultaneous request.
                if (flush || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (cpu_req) begin
                    rw_d    = cpu_rw;
                    addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = cpu_wdata;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!rw_q && hit) begin
                    rdata_d = data_arr[idx];
                    done_d  = 1'b1;
                    hit_d   = sat_inc(hit_q);
                    state_d = IDLE;
                end else begin
                    if (hit) hit_d = sat_inc(hit_q);
                    else     miss_d = sat_inc(miss_q);
                    // Write hits update the line; write misses do not allocate.
                    if (rw_q && hit) begin
                        data_we   = 1'b1;
                        data_wval = wdata_q;
                    end
                    mem_req_d   = 1'b1;
                    mem_we_d    = rw_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = rw_q ? MEM_WR : MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    data_we      = 1'b1;
                    tag_we       = 1'b1;
                    data_wval    = mem_rdata;
                    valid_d[idx] = 1'b1;
                    rdata_d      = mem_rdata;
                    done_d       = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_ack) begin
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush seen while busy is remembered and applied once back in IDLE.
        if (flush && state_q != IDLE) flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_arr[idx] <= data_wval;
        if (tag_we)  tag_arr[idx]  <= tag;
    end

    assign cpu_ready = (state_q == IDLE) && !flush && !flush_pend_q;
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_dir_mapp_cache.sv
// Self-checking bench for dir_mapp_cache (INDEX_W=4). A second instance with
// 2-bit counters shares all inputs so that counter saturation is observed
// alongside the main behaviour.
module tb_dir_mapp_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_rw, flush, mem_ack;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic        cpu_ready, cpu_done, mem_req, mem_we;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic [15:0] hit_cnt, miss_cnt;

    logic        s_ready, s_done, s_req, s_we;
    logic [31:0] s_rdata, s_addr, s_wdata;
    logic [1:0]  s_hit, s_miss;

    always #5 clk = ~clk;

    dir_mapp_cache #(.ADDR_W(32), .DATA_W(32), .INDEX_W(4), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_ready(cpu_ready),
        .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

    dir_mapp_cache #(.ADDR_W(32), .DATA_W(32), .INDEX_W(4), .COUNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_ready(s_ready),
        .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(s_done), .cpu_rdata(s_rdata), .flush(flush),
        .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(s_hit), .miss_cnt(s_miss));

    // Reference model: what the cache should hold, by line.
    bit [15:0]   mvalid;
    logic [25:0] mtag  [16];
    logic [31:0] mdata [16];
    int          mhit, mmiss;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk_counts();
        chk("hit_cnt",    hit_cnt,  64'(sat(mhit, 65535)));
        chk("miss_cnt",   miss_cnt, 64'(sat(mmiss, 65535)));
        chk("hit_cnt_s",  s_hit,    64'(sat(mhit, 3)));
        chk("miss_cnt_s", s_miss,   64'(sat(mmiss, 3)));
    endtask

    task automatic model_reset();
        mvalid = '0;
        mhit   = 0;
        mmiss  = 0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !cpu_ready; i++) begin
            @(posedge clk); #1;
        end
        chk("ready_wait", cpu_ready, 1);
    endtask

    task automatic txn(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly, input bit mflush);
        int          idx;
        logic [25:0] tg;
        logic [31:0] wa;
        bit          hit;
        idx = int'(addr[5:2]);
        tg  = addr[31:6];
        wa  = {addr[31:2], 2'b00};
        hit = mvalid[idx] && (mtag[idx] == tg);
        wait_ready();
        cpu_req = 1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk); #1;
        // Scramble the CPU bus to show the latched request is used.
        cpu_req = 0; cpu_rw = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
        @(posedge clk); #1;
        if (hit) mhit++; else mmiss++;
        if (!rw && hit) begin
            chk("rhit_done",  cpu_done,  1);
            chk("rhit_data",  cpu_rdata, mdata[idx]);
            chk("rhit_nomem", mem_req,   0);
        end else begin
            chk("mem_req",  mem_req,  1);
            chk("mem_we",   mem_we,   rw);
            chk("mem_addr", mem_addr, wa);
            if (rw) chk("mem_wdata", mem_wdata, wd);
            chk("busy_nodone", cpu_done, 0);
            if (rw && hit) mdata[idx] = wd;
            if (mflush) flush = 1;
            for (int d = 0; d <= dly; d++) begin
                if (d == dly) begin
                    mem_ack = 1; mem_rdata = rd;
                end else begin
                    mem_rdata = $urandom;
                end
                chk("busy_ready", cpu_ready, 0);
                chk("hold_req",   mem_req,   1);
                chk("hold_addr",  mem_addr,  wa);
                chk("hold_we",    mem_we,    rw);
                if (rw) chk("hold_wdata", mem_wdata, wd);
                @(posedge clk); #1;
                flush = 0; mem_ack = 0;
            end
            chk("mem_done", cpu_done, 1);
            chk("req_drop", mem_req,  0);
            if (!rw) begin
                chk("refill_data", cpu_rdata, rd);
                mvalid[idx] = 1'b1;
                mtag[idx]   = tg;
                mdata[idx]  = rd;
            end
            if (mflush) mvalid = '0;
        end
        chk_counts();
        @(posedge clk); #1;
        chk("done_pulse", cpu_done, 0);
    endtask

    task automatic flush_req(input logic [31:0] addr);
        wait_ready();
        flush = 1; cpu_req = 1; cpu_rw = 0; cpu_addr = addr;
        #1;
        chk("flush_ready", cpu_ready, 0);
        @(posedge clk); #1;
        flush = 0; cpu_req = 0;
        mvalid = '0;
        chk("flush_noreq", mem_req, 0);
        @(posedge clk); #1;
        chk("flush_nodone", cpu_done, 0);
        chk("flush_noreq2", mem_req,  0);
    endtask

    task automatic reset_mid(input logic [31:0] addr);
        wait_ready();
        cpu_req = 1; cpu_rw = 0; cpu_addr = addr;
        @(posedge clk); #1;
        cpu_req = 0;
        @(posedge clk); #1;
        chk("rst_pre_req", mem_req, 1);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_req_drop", mem_req,   0);
        chk("rst_nodone",   cpu_done,  0);
        chk("rst_ready",    cpu_ready, 1);
        chk_counts();
        @(posedge clk); #1;
        chk("rst_nodone2", cpu_done, 0);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; cpu_req = 0; cpu_rw = 0; cpu_addr = 0; cpu_wdata = 0;
        flush = 0; mem_ack = 0; mem_rdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  cpu_ready, 1);
        chk("rst_done",   cpu_done,  0);
        chk("rst_rdata",  cpu_rdata, 0);
        chk("rst_req",    mem_req,   0);
        chk("rst_we",     mem_we,    0);
        chk("rst_maddr",  mem_addr,  0);
        chk("rst_mwdata", mem_wdata, 0);
        chk_counts();
        rst_n = 1;
        @(posedge clk); #1;

        // Basic miss, hit, conflict eviction, write-through.
        txn(0, 32'h40, 0, 32'hDEADBEEF, 0, 0);
        txn(0, 32'h40, 0, 0, 0, 0);
        txn(0, 32'h80, 0, 32'hA5A50080, 1, 0);
        txn(0, 32'h40, 0, 32'h0BADF00D, 0, 0);
        chk("miss_cnt_3", miss_cnt, 3);
        txn(1, 32'h40, 32'h12345678, 0, 0, 0);
        txn(0, 32'h40, 0, 0, 0, 0);
        txn(1, 32'hC4, 32'hCAFEF00D, 0, 2, 0);
        txn(0, 32'hC4, 0, 32'h000000C4, 0, 0);

        // Flush in IDLE blocks a request; flush during refill.
        flush_req(32'h40);
        txn(0, 32'h40, 0, 32'h11112222, 2, 1);
        txn(0, 32'h40, 0, 32'h33334444, 0, 0);

        // Long ack wait, then reset in the middle of a refill.
        txn(0, 32'h40, 0, 0, 5, 0);
        txn(0, 32'h84, 0, 32'h55556666, 5, 0);
        reset_mid(32'h80);
        txn(0, 32'h40, 0, 32'h77778888, 0, 0);

        // Counter saturation on the narrow-counter instance.
        for (int i = 0; i < 5; i++) txn(0, 32'h40, 0, 0, 0, 0);
        chk("sat_hit_s",  s_hit,  3);
        chk("sat_miss_s", s_miss, 1);
        chk("hit_cnt_5",  hit_cnt, 5);

        // Randomized traffic over a small address pool so hits and conflicts occur.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 24) == 0) flush_req(a);
            else txn(1'($urandom), a, $urandom, $urandom, $urandom_range(0, 3),
                     $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d, expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dir_mapp_cache.md
# dir_mapp_cache

Parametrised direct-mapped, write-through, no-write-allocate cache with tag/valid arrays, a miss-handling state machine and a valid/ack handshake to backing memory. It sits between the CPU load/store path and word-wide data memory, replacing the untagged single-array memory model. It adds hit/miss detection, refill on read miss, flush, and saturating hit/miss counters.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- INDEX_W, 6, index bits; LINES = 2^INDEX_W one-word lines
- COUNT_W, 16, hit/miss counter width
- Derived: TAG_W = ADDR_W-INDEX_W-2; index = addr[INDEX_W+1:2]; tag = addr[ADDR_W-1:INDEX_W+2]; addr[1:0] ignored

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request valid
- cpu_ready  out  1  = (state==IDLE) && !flush && !flush_pend
- cpu_rw  in  1  0 read, 1 write
- cpu_addr  in  ADDR_W  request address
- cpu_wdata  in  DATA_W  write data
- cpu_done  out  1  one-cycle completion pulse (read or write)
- cpu_rdata  out  DATA_W  read data, valid while cpu_done=1 for reads
- flush  in  1  invalidate all lines
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 write, 0 read
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completion; mem_rdata valid same cycle for reads
- mem_rdata  in  DATA_W  read data
- hit_cnt  out  COUNT_W  saturating hit count
- miss_cnt  out  COUNT_W  saturating miss count

## Operation
- States: IDLE, CMP, MEM_RD, MEM_WR.
- IDLE: cpu_req && cpu_ready at an edge latches rw/addr/wdata -> CMP.
- CMP (one cycle): hit = valid[index] && tag_arr[index]==tag.
  - Read hit: cpu_rdata<=data_arr[index], cpu_done<=1, hit_cnt++ -> IDLE.
  - Read miss: mem_req<=1, mem_we<=0, mem_addr<=addr, miss_cnt++ -> MEM_RD.
  - Write hit: data_arr[index]<=wdata, hit_cnt++; write miss: arrays unchanged, miss_cnt++. Both: mem_req<=1, mem_we<=1, mem_addr, mem_wdata -> MEM_WR.
- MEM_RD: on mem_ack: data_arr<=mem_rdata, tag_arr<=tag, valid<=1 (evicts prior line), cpu_rdata<=mem_rdata, cpu_done<=1, mem_req<=0 -> IDLE.
- MEM_WR: on mem_ack: cpu_done<=1, mem_req<=0 -> IDLE.
- mem_addr/mem_we/mem_wdata stable while mem_req=1; mem_ack ignored when mem_req=0.
- Flush: in IDLE clears all valid bits at the next edge; takes priority over a simultaneous cpu_req (not accepted). Flush asserted outside IDLE sets flush_pend, applied on the edge after returning to IDLE; the in-flight refill completes first (its line is then invalidated).
- Counters saturate at 2^COUNT_W-1; cleared only by reset, not by flush.
- One request outstanding; no bypass of cpu_addr while busy.

## Timing
- Reset (async, immediate): state IDLE, all valid=0, cpu_done=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_cnt=0, miss_cnt=0, flush_pend=0; cpu_ready=1 if flush=0. Tag/data arrays not reset.
- Reset mid-transaction aborts: mem_req drops immediately, no cpu_done, partial refill discarded.
- Read hit: accepted at edge E0, cpu_done high in cycle after E1 (2 cycles from request); cpu_ready high same cycle -> one hit per 2 cycles.
- Miss/write: mem_req high from E1; with mem_ack in the first mem_req cycle, cpu_done high after E2. Each ack-wait cycle adds one.
- cpu_done is exactly one cycle wide.

## Test plan
- INDEX_W=4. Reset, read 0x40 -> mem_req, we=0, mem_addr=0x40; ack with 0xDEADBEEF -> cpu_done, cpu_rdata=0xDEADBEEF, miss_cnt=1; reread 0x40 -> no mem_req, done 2 cycles after request, hit_cnt=1.
- Conflict: after filling 0x40, read 0x80 (same index 0, tag 2) -> miss, refill; read 0x40 -> miss again, miss_cnt=3.
- Write hit 0x40 data 0x12345678 -> mem write addr 0x40 data 0x12345678; read 0x40 hit returns 0x12345678. Write miss 0xC4 -> mem write, then read 0xC4 misses.
- Flush in IDLE with cpu_req high -> request not accepted that cycle; subsequent reads of filled lines miss. Flush during MEM_RD -> refill completes with done, next read of that address misses.
- mem_ack delayed 5 cycles: mem_addr/mem_we/mem_wdata stable, cpu_ready=0 throughout; rst_n low during MEM_RD -> mem_req=0 immediately, no cpu_done, prior hit address now misses, counters 0.
- COUNT_W=2: one miss then 5 hits to 0x40 -> hit_cnt=3 (saturated), miss_cnt=1.
